mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory bus between the instruction-fetch port and the data-memory (load/store) port of the five-stage pipeline. It runs one bus transaction at a time, returns response data to the owning requester and discards fetch responses made stale by a control-flow flush. Data accesses have priority, with a bounded streak so fetch is never starved.

---
 rtl/eel_mem_pkg.sv | 24 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/eel_mem_pkg.sv
// Shared definitions for the memory-port arbiter of the five-stage pipeline.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the current bus transaction
//   SZ_*        : MEM_SIZE / BUS_SIZE access-size encodings
package eel_mem_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_I  = 3'd1,
      WAIT_I = 3'd2,
      REQ_D  = 3'd3,
      WAIT_D = 3'd4
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory bus between the
// instruction-fetch port (IF_*) and the load/store port (MEM_*).
// One transaction is in flight at a time. Data requests win arbitration,
// but after D_STREAK_MAX consecutive data grants with a fetch waiting the
// fetch is granted next. A FLUSH withdraws an ungranted fetch or marks a
// granted fetch so its response is dropped.
//
// Ports
//   CLK, RST                         clock, synchronous active-high reset
//   IF_REQ, IF_ADDR                  fetch request (level) and address
//   IF_RDATA, IF_VALID               fetched word and one-cycle completion
//   FLUSH                            kills the pending fetch
//   MEM_REQ/WE/ADDR/WDATA/SIZE       data request (level) and fields
//   MEM_RDATA, MEM_VALID             load data and one-cycle completion
//   BUS_REQ/WE/ADDR/WDATA/SIZE       registered address phase
//   BUS_GNT                          address phase accepted this cycle
//   BUS_RVALID, BUS_RDATA            response / write-ack
module mem_port_arbiter
   import eel_mem_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned D_STREAK_MAX = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic [DATA_W-1:0] IF_RDATA,
   output logic              IF_VALID,
   input  logic              FLUSH,
   input  logic              MEM_REQ,
   input  logic              MEM_WE,
   input  logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [DATA_W-1:0] MEM_WDATA,
   input  logic [1:0]        MEM_SIZE,
   output logic [DATA_W-1:0] MEM_RDATA,
   output logic              MEM_VALID,
   output logic              BUS_REQ,
   output logic              BUS_WE,
   output logic [ADDR_W-1:0] BUS_ADDR,
   output logic [DATA_W-1:0] BUS_WDATA,
   output logic [1:0]        BUS_SIZE,
   input  logic              BUS_GNT,
   input  logic              BUS_RVALID,
   input  logic [DATA_W-1:0] BUS_RDATA
);

   localparam int unsigned         STREAK_W   = $clog2(D_STREAK_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(D_STREAK_MAX);

   arb_state_t          state_q;
   arb_state_t          state_nx;
   logic [STREAK_W-1:0] streak_q;
   logic                discard_q;
   logic                if_elig;
   logic                mem_elig;
   logic                grant_vld;
   owner_t              grant_own;

   // Next-state and arbitration decision.
   always_comb begin
      state_nx  = state_q;
      grant_vld = 1'b0;
      grant_own = OWN_I;
      // A requester whose VALID is high this cycle is still holding the
      // request it just completed, so it takes no part in arbitration.
      if_elig   = IF_REQ  && !IF_VALID;
      mem_elig  = MEM_REQ && !MEM_VALID;

      case (state_q)
         IDLE: begin
            if (mem_elig && (streak_q < STREAK_LIM)) begin
               grant_vld = 1'b1;
               grant_own = OWN_D;
            end else if (if_elig) begin
               grant_vld = 1'b1;
               grant_own = OWN_I;
            end else if (mem_elig) begin
               grant_vld = 1'b1;
               grant_own = OWN_D;
            end
            if (grant_vld) begin
               state_nx = (grant_own == OWN_D) ? REQ_D : REQ_I;
            end
         end
         REQ_I: begin
            if (BUS_GNT) begin
               state_nx = WAIT_I;
            end else if (FLUSH) begin
               state_nx = IDLE;
            end
         end
         WAIT_I: begin
            if (BUS_RVALID) begin
               state_nx = IDLE;
            end
         end
         REQ_D: begin
            if (BUS_GNT) begin
               state_nx = WAIT_D;
            end
         end
         WAIT_D: begin
            if (BUS_RVALID) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         discard_q <= 1'b0;
         BUS_REQ   <= 1'b0;
         BUS_WE    <= 1'b0;
         BUS_ADDR  <= '0;
         BUS_WDATA <= '0;
         BUS_SIZE  <= '0;
         IF_VALID  <= 1'b0;
         IF_RDATA  <= '0;
         MEM_VALID <= 1'b0;
         MEM_RDATA <= '0;
      end else begin
         state_q   <= state_nx;
         BUS_REQ   <= (state_nx == REQ_I) || (state_nx == REQ_D);
         IF_VALID  <= 1'b0;
         MEM_VALID <= 1'b0;

         // Streak only counts data grants made while a fetch is waiting.
         if (state_q == IDLE) begin
            if (!IF_REQ) begin
               streak_q <= '0;
            end else if (grant_vld && (grant_own == OWN_I)) begin
               streak_q <= '0;
            end else if (grant_vld && (streak_q < STREAK_LIM)) begin
               streak_q <= streak_q + 1'b1;
            end
         end

         if (grant_vld) begin
            if (grant_own == OWN_D) begin
               BUS_WE    <= MEM_WE;
               BUS_ADDR  <= MEM_ADDR;
               BUS_WDATA <= MEM_WDATA;
               BUS_SIZE  <= MEM_SIZE;
            end else begin
               BUS_WE    <= 1'b0;
               BUS_ADDR  <= IF_ADDR;
               BUS_WDATA <= '0;
               BUS_SIZE  <= SZ_WORD;
            end
         end

         if ((state_q == REQ_I) && BUS_GNT && FLUSH) begin
            discard_q <= 1'b1;
         end

         if (state_q == WAIT_I) begin
            if (BUS_RVALID) begin
               discard_q <= 1'b0;
               // A flush in the response cycle also drops the response.
               if (!discard_q && !FLUSH) begin
                  IF_RDATA <= BUS_RDATA;
                  IF_VALID <= 1'b1;
               end
            end else if (FLUSH) begin
               discard_q <= 1'b1;
            end
         end

         if ((state_q == WAIT_D) && BUS_RVALID) begin
            MEM_RDATA <= BUS_RDATA;
            MEM_VALID <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random fetch/data requesters, a
// random-latency bus responder, random flushes and resets, all checked
// cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int D_MAX = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IF_REQ = 1'b0;
   logic [31:0] IF_ADDR = '0;
   logic [31:0] IF_RDATA;
   logic        IF_VALID;
   logic        FLUSH = 1'b0;
   logic        MEM_REQ = 1'b0;
   logic        MEM_WE = 1'b0;
   logic [31:0] MEM_ADDR = '0;
   logic [31:0] MEM_WDATA = '0;
   logic [1:0]  MEM_SIZE = '0;
   logic [31:0] MEM_RDATA;
   logic        MEM_VALID;
   logic        BUS_REQ;
   logic        BUS_WE;
   logic [31:0] BUS_ADDR;
   logic [31:0] BUS_WDATA;
   logic [1:0]  BUS_SIZE;
   logic        BUS_GNT = 1'b0;
   logic        BUS_RVALID = 1'b0;
   logic [31:0] BUS_RDATA = '0;

   mem_port_arbiter #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .D_STREAK_MAX(D_MAX)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IF_REQ    (IF_REQ),
      .IF_ADDR   (IF_ADDR),
      .IF_RDATA  (IF_RDATA),
      .IF_VALID  (IF_VALID),
      .FLUSH     (FLUSH),
      .MEM_REQ   (MEM_REQ),
      .MEM_WE    (MEM_WE),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_WDATA (MEM_WDATA),
      .MEM_SIZE  (MEM_SIZE),
      .MEM_RDATA (MEM_RDATA),
      .MEM_VALID (MEM_VALID),
      .BUS_REQ   (BUS_REQ),
      .BUS_WE    (BUS_WE),
      .BUS_ADDR  (BUS_ADDR),
      .BUS_WDATA (BUS_WDATA),
      .BUS_SIZE  (BUS_SIZE),
      .BUS_GNT   (BUS_GNT),
      .BUS_RVALID(BUS_RVALID),
      .BUS_RDATA (BUS_RDATA)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          own_d;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [1:0]  size;
      bit          granted;
      bit          killed;
   } txn_t;

   txn_t        cur;
   bit          busy = 1'b0;
   int          streak = 0;
   bit          m_iv, m_mv, want_i, want_d;
   logic        e_bus_req = 1'b0, e_bus_we = 1'b0;
   logic [31:0] e_bus_addr = '0, e_bus_wdata = '0;
   logic [1:0]  e_bus_size = '0;
   logic        e_if_valid = 1'b0, e_mem_valid = 1'b0;
   logic [31:0] e_if_rdata = '0, e_mem_rdata = '0;

   always @(posedge CLK) begin
      m_iv = e_if_valid;
      m_mv = e_mem_valid;
      e_if_valid  = 1'b0;
      e_mem_valid = 1'b0;
      if (RST) begin
         busy = 1'b0;        streak = 0;
         e_bus_req = 1'b0;   e_bus_we = 1'b0;
         e_bus_addr = '0;    e_bus_wdata = '0;   e_bus_size = '0;
         e_if_rdata = '0;    e_mem_rdata = '0;
      end else if (!busy) begin
         want_i = IF_REQ && !m_iv;
         want_d = MEM_REQ && !m_mv;
         if (want_d && (streak < D_MAX || !want_i)) begin
            cur.own_d = 1'b1;   cur.addr = MEM_ADDR;  cur.we = MEM_WE;
            cur.wdata = MEM_WDATA; cur.size = MEM_SIZE;
            busy = 1'b1;
         end else if (want_i) begin
            cur.own_d = 1'b0;   cur.addr = IF_ADDR;   cur.we = 1'b0;
            cur.wdata = '0;     cur.size = 2'b10;
            busy = 1'b1;
         end
         cur.granted = 1'b0;
         cur.killed  = 1'b0;
         if (busy) begin
            e_bus_req = 1'b1;      e_bus_we = cur.we;   e_bus_addr = cur.addr;
            e_bus_wdata = cur.wdata; e_bus_size = cur.size;
         end
         if (!IF_REQ || (busy && !cur.own_d)) streak = 0;
         else if (busy && streak < D_MAX) streak++;
      end else if (!cur.granted) begin
         if (BUS_GNT) begin
            cur.granted = 1'b1;
            e_bus_req = 1'b0;
            if (!cur.own_d && FLUSH) cur.killed = 1'b1;
         end else if (!cur.own_d && FLUSH) begin
            busy = 1'b0;
            e_bus_req = 1'b0;
         end
      end else begin
         if (!cur.own_d && FLUSH) cur.killed = 1'b1;
         if (BUS_RVALID) begin
            busy = 1'b0;
            if (cur.own_d) begin
               e_mem_valid = 1'b1;
               e_mem_rdata = BUS_RDATA;
            end else if (!cur.killed) begin
               e_if_valid = 1'b1;
               e_if_rdata = BUS_RDATA;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // phase knobs: fetch %, data %, grant %, max response latency, flush %
   int p_if  [4] = '{30, 100, 70, 90};
   int p_mem [4] = '{30, 100, 60, 90};
   int p_gnt [4] = '{100, 100, 50, 70};
   int p_lat [4] = '{0, 0, 3, 4};
   int p_fl  [4] = '{0, 0, 15, 30};

   bit outstanding = 1'b0;
   int lat = 0;
   bit prev_req = 1'b0, prev_gnt = 1'b0;
   bit if_seen = 1'b0, mem_seen = 1'b0;
   int n_ifv = 0, n_memv = 0;

   initial begin
      for (int ph = 0; ph < 4; ph++) begin
         for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge CLK);
            check_val("bus_req",   BUS_REQ,   e_bus_req);
            check_val("bus_we",    BUS_WE,    e_bus_we);
            check_val("bus_addr",  BUS_ADDR,  e_bus_addr);
            check_val("bus_size",  BUS_SIZE,  e_bus_size);
            if (e_bus_we) check_val("bus_wdata", BUS_WDATA, e_bus_wdata);
            check_val("if_valid",  IF_VALID,  e_if_valid);
            check_val("if_rdata",  IF_RDATA,  e_if_rdata);
            check_val("mem_valid", MEM_VALID, e_mem_valid);
            check_val("mem_rdata", MEM_RDATA, e_mem_rdata);
            if (IF_VALID)  n_ifv++;
            if (MEM_VALID) n_memv++;

            // bus responder; a reset does not cancel a response already owed
            BUS_RVALID = 1'b0;
            if (prev_req && prev_gnt) begin
               outstanding = 1'b1;
               lat = $urandom_range(0, p_lat[ph]);
            end
            if (outstanding) begin
               if (lat == 0) begin
                  BUS_RVALID = 1'b1;
                  BUS_RDATA  = $urandom;
                  outstanding = 1'b0;
               end else begin
                  lat--;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               BUS_RVALID = 1'b1;
               BUS_RDATA  = $urandom;
            end
            if (BUS_REQ)
               BUS_GNT = !outstanding && ($urandom_range(0, 99) < p_gnt[ph]);
            else
               BUS_GNT = ($urandom_range(0, 7) == 0);
            prev_req = BUS_REQ;
            prev_gnt = BUS_GNT;

            // fetch requester: holds through its VALID cycle, changes after
            if (if_seen) begin
               IF_REQ = ($urandom_range(0, 99) < p_if[ph]);
               if (IF_REQ) IF_ADDR = {$urandom_range(0, 65535), 2'b00};
            end else if (!IF_REQ && ($urandom_range(0, 99) < p_if[ph])) begin
               IF_REQ  = 1'b1;
               IF_ADDR = {$urandom_range(0, 65535), 2'b00};
            end
            if_seen = IF_VALID;
            FLUSH = ($urandom_range(0, 99) < p_fl[ph]);
            if (FLUSH && IF_REQ) IF_ADDR = {$urandom_range(0, 65535), 2'b00};

            // data requester
            if (mem_seen || (!MEM_REQ && ($urandom_range(0, 99) < p_mem[ph]))) begin
               MEM_REQ = mem_seen ? ($urandom_range(0, 99) < p_mem[ph]) : 1'b1;
               MEM_WE    = $urandom_range(0, 1);
               MEM_ADDR  = $urandom;
               MEM_WDATA = $urandom;
               MEM_SIZE  = 2'($urandom_range(0, 2));
            end
            mem_seen = MEM_VALID;

            RST = (cyc < 2) || ($urandom_range(0, 399) == 0);
            if (RST) begin
               IF_REQ = 1'b0;  MEM_REQ = 1'b0;  FLUSH = 1'b0;
               if_seen = 1'b0; mem_seen = 1'b0;
            end
         end
      end
      @(negedge CLK);
      check_val("if_activity",  64'(n_ifv > 0),  64'd1);
      check_val("mem_activity", 64'(n_memv > 0), 64'd1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
